// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b controller, LSB first, built from two chained half_sub cells.
// Define SERIAL_SUB_ABORT_EN to add the abort_i port.
module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic c
);
    assign d = a ^ b;
    assign c = ~a & b;
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             res_valid_o,
`ifdef SERIAL_SUB_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             res_ready_i
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic             borrow_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_nxt;
    logic             d1, c1, diff_k, c2, borrow_d;
    logic             last, abort;

`ifdef SERIAL_SUB_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    half_sub hs0 (.a(a_q[0]), .b(b_q[0]),   .d(d1),     .c(c1));
    half_sub hs1 (.a(d1),     .b(borrow_q), .d(diff_k), .c(c2));

    assign borrow_d = c1 | c2;
    assign res_nxt  = {diff_k, res_q};
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (start_i) nxt = RUN;
            RUN: begin
                if (abort)     nxt = IDLE;
                else if (last) nxt = DONE;
            end
            DONE: if (abort || res_ready_i) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_o     = (state == IDLE);
        res_valid_o = (state == DONE);
    end

    // Operand registers shift right so bit 0 is always the bit in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt      <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        cnt      <= '0;
                        borrow_q <= 1'b0;
                        res_q    <= '0;
                        diff_o   <= '0;
                        borrow_o <= 1'b0;
                    end else begin
                        a_q      <= a_q >> 1;
                        b_q      <= b_q >> 1;
                        res_q    <= res_nxt[WIDTH-1:1];
                        borrow_q <= borrow_d;
                        if (last) begin
                            diff_o   <= res_nxt;
                            borrow_o <= borrow_d;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        cnt      <= '0;
                        borrow_q <= 1'b0;
                        res_q    <= '0;
                        diff_o   <= '0;
                        borrow_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed test of serial_sub_ctrl (WIDTH=8), hand-computed expectations.
// Abort scenario runs only when SERIAL_SUB_ABORT_EN is defined.
module tb_serial_sub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] diff;
    logic       borrow;
    logic       res_valid;
    logic       res_ready = 1'b0;
`ifdef SERIAL_SUB_ABORT_EN
    logic       abort = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .ready_o     (ready),
        .a_i         (a),
        .b_i         (b),
        .diff_o      (diff),
        .borrow_o    (borrow),
        .res_valid_o (res_valid),
`ifdef SERIAL_SUB_ABORT_EN
        .abort_i     (abort),
`endif
        .res_ready_i (res_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, check latency, result and handshake.
    task automatic run_op(input string tag, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] ed,
                          input logic eb);
        a = av; b = bv; start = 1'b1; res_ready = 1'b0;
        step();
        chk({tag, "_busy"}, ready, 1'b0);
        start = 1'b0; a = ~av; b = 8'h5A;
        repeat (7) step();
        chk({tag, "_early"}, res_valid, 1'b0);
        step();
        chk({tag, "_valid"}, res_valid, 1'b1);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_vdrop"}, res_valid, 1'b0);
        chk({tag, "_rdy"}, ready, 1'b1);
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", ready, 1'b1);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_borrow", borrow, 1'b0);

        run_op("op05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        run_op("op03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        run_op("op00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        run_op("opFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("op80_7F", 8'h80, 8'h7F, 8'h01, 1'b0);

        // Backpressure with start held and new operands present
        a = 8'h10; b = 8'h01; start = 1'b1;
        step();
        a = 8'h55; b = 8'h11;
        repeat (8) step();
        chk("bp_valid", res_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_diff", diff, 8'h0F);
            chk("bp_hold_rdy", ready, 1'b0);
            chk("bp_hold_valid", res_valid, 1'b1);
            step();
        end
        chk("bp_diff_end", diff, 8'h0F);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_idle_rdy", ready, 1'b1);
        chk("bp_idle_diff", diff, 8'h0F);
        step();
        start = 1'b0;
        chk("bp_acc_busy", ready, 1'b0);
        repeat (7) step();
        chk("bp_new_early", res_valid, 1'b0);
        step();
        chk("bp_new_valid", res_valid, 1'b1);
        chk("bp_new_diff", diff, 8'h44);
        chk("bp_new_borrow", borrow, 1'b0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Reset in the middle of a run
        a = 8'h05; b = 8'h03; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("mid_busy", ready, 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_rdy", ready, 1'b1);
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_diff", diff, 8'h00);
        chk("mid_rst_borrow", borrow, 1'b0);
        rst_n = 1'b1;
        step();
        run_op("op09_04", 8'h09, 8'h04, 8'h05, 1'b0);

`ifdef SERIAL_SUB_ABORT_EN
        a = 8'h33; b = 8'h11; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_rdy", ready, 1'b1);
        chk("ab_valid", res_valid, 1'b0);
        chk("ab_diff", diff, 8'h00);
        for (int i = 0; i < 10; i++) begin
            chk("ab_no_valid", res_valid, 1'b0);
            step();
        end
        run_op("op20_21", 8'h20, 8'h21, 8'hFF, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
